// File: rtl/fifo_24_drain_checker_if.sv
// FIFO read-side bundle between the drain checker (master) and an upstream FIFO (slave).
`timescale 1ns/1ps
interface fifo_24_drain_checker_if #(
    parameter int WIDTH = 24
);
    logic             fifo_empty;
    logic             fifo_rd_en;
    logic [WIDTH-1:0] fifo_dout;

    modport master (
        input  fifo_empty,
        input  fifo_dout,
        output fifo_rd_en
    );

    modport slave (
        output fifo_empty,
        output fifo_dout,
        input  fifo_rd_en
    );
endinterface

// File: rtl/fifo_24_drain_checker.sv
// Drains an upstream FIFO and compares every captured word with the one captured
// COMP_OFFSET captures earlier, counting mismatches.
`timescale 1ns/1ps
module fifo_24_drain_checker #(
    parameter int WIDTH       = 24,
    parameter int COMP_OFFSET = 24,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic                     restart,
    input  logic                     clr_cnt,
    fifo_24_drain_checker_if.master  fifo,
    output logic [WIDTH-1:0]         dout,
    output logic                     dout_valid,
    output logic                     comp,
    output logic                     comp_valid,
    output logic [CNT_WIDTH-1:0]     mismatch_cnt,
    output logic                     err_sticky,
    output logic [1:0]               state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        CHECK = 2'd2
    } state_t;

    localparam int                  FILL_W    = $clog2(COMP_OFFSET + 1);
    localparam logic [FILL_W-1:0]   FILL_FULL = FILL_W'(COMP_OFFSET);

    state_t                 state_reg, state_next;
    logic [FILL_W-1:0]      fill_reg, fill_next;
    logic                   pending_reg;
    logic                   capture;
    logic                   history_full;
    logic [WIDTH-1:0]       hist_reg [COMP_OFFSET];

    logic [WIDTH-1:0]       dout_reg;
    logic                   dout_valid_reg;
    logic                   comp_reg;
    logic                   comp_valid_reg;
    logic [CNT_WIDTH-1:0]   mismatch_cnt_reg;
    logic                   err_sticky_reg;
    logic                   mismatch_evt;

    // A pop issued last cycle lands now unless restart discards it.
    assign capture      = pending_reg & ~restart;
    assign history_full = (fill_reg == FILL_FULL);
    assign mismatch_evt = comp_valid_reg & ~comp_reg;

    always_comb begin
        fill_next = fill_reg;
        if (restart)
            fill_next = '0;
        else if (capture && !history_full)
            fill_next = fill_reg + FILL_W'(1);
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    // FSM: next-state logic
    always_comb begin
        state_next = state_reg;
        if (restart) begin
            state_next = enable ? PRIME : IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (enable)
                        state_next = (fill_next == FILL_FULL) ? CHECK : PRIME;
                end
                PRIME: begin
                    if (!enable)
                        state_next = IDLE;
                    else if (fill_next == FILL_FULL)
                        state_next = CHECK;
                end
                CHECK: begin
                    if (!enable)
                        state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // FSM: outputs
    always_comb begin
        fifo.fifo_rd_en = enable & ~fifo.fifo_empty & (state_reg != IDLE) & ~restart;
        state           = state_reg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_reg    <= '0;
            pending_reg <= 1'b0;
        end else begin
            fill_reg    <= fill_next;
            pending_reg <= fifo.fifo_rd_en;
        end
    end

    // History shift register: entry 0 is the newest capture, the last entry the oldest.
    generate
        for (genvar gi = 0; gi < COMP_OFFSET; gi++) begin : g_hist
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    hist_reg[gi] <= '0;
                else if (restart)
                    hist_reg[gi] <= '0;
                else if (capture)
                    hist_reg[gi] <= (gi == 0) ? fifo.fifo_dout : hist_reg[(gi == 0) ? 0 : gi - 1];
            end
        end
    endgenerate

    // Comparison is qualified by a full history, so an in-flight pop that lands
    // after enable drops is still checked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_reg       <= '0;
            dout_valid_reg <= 1'b0;
            comp_reg       <= 1'b0;
            comp_valid_reg <= 1'b0;
        end else begin
            dout_valid_reg <= capture;
            comp_valid_reg <= capture & history_full;
            comp_reg       <= capture & history_full &
                              (fifo.fifo_dout == hist_reg[COMP_OFFSET-1]);
            if (capture)
                dout_reg <= fifo.fifo_dout;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mismatch_cnt_reg <= '0;
            err_sticky_reg   <= 1'b0;
        end else if (clr_cnt) begin
            mismatch_cnt_reg <= '0;
            err_sticky_reg   <= 1'b0;
        end else if (mismatch_evt) begin
            if (mismatch_cnt_reg != {CNT_WIDTH{1'b1}})
                mismatch_cnt_reg <= mismatch_cnt_reg + CNT_WIDTH'(1);
            err_sticky_reg <= 1'b1;
        end
    end

    assign dout         = dout_reg;
    assign dout_valid   = dout_valid_reg;
    assign comp         = comp_reg;
    assign comp_valid   = comp_valid_reg;
    assign mismatch_cnt = mismatch_cnt_reg;
    assign err_sticky   = err_sticky_reg;

endmodule

// File: tb/tb_fifo_24_drain_checker.sv
// Directed bench for fifo_24_drain_checker: a small FIFO model feeds the DUT and every
// capture is logged and compared against hand-set expectations.
`timescale 1ns/1ps
module tb_fifo_24_drain_checker;

    localparam int W   = 24;
    localparam int OFF = 24;
    localparam int CW  = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic          restart;
    logic          clr_cnt;
    logic [W-1:0]  dout;
    logic          dout_valid;
    logic          comp;
    logic          comp_valid;
    logic [CW-1:0] mismatch_cnt;
    logic          err_sticky;
    logic [1:0]    state;

    fifo_24_drain_checker_if #(.WIDTH(W)) fifo_if ();

    fifo_24_drain_checker #(.WIDTH(W), .COMP_OFFSET(OFF), .CNT_WIDTH(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .restart      (restart),
        .clr_cnt      (clr_cnt),
        .fifo         (fifo_if),
        .dout         (dout),
        .dout_valid   (dout_valid),
        .comp         (comp),
        .comp_valid   (comp_valid),
        .mismatch_cnt (mismatch_cnt),
        .err_sticky   (err_sticky),
        .state        (state)
    );

    always #5 clk = ~clk;

    // Upstream FIFO model: words pushed by the stimulus, popped one cycle after rd_en.
    logic [W-1:0] mem [0:1023];
    int           wr_cnt = 0;
    int           rd_ptr = 0;
    logic         empty_force = 1'b0;
    logic [W-1:0] exp_q [$];

    assign fifo_if.fifo_empty = (rd_ptr == wr_cnt) || empty_force;

    initial fifo_if.fifo_dout = '0;
    always @(posedge clk) begin
        if (fifo_if.fifo_rd_en) begin
            fifo_if.fifo_dout <= mem[rd_ptr];
            rd_ptr            <= rd_ptr + 1;
        end
    end

    // Capture log, one line per captured word.
    logic [W-1:0] cap_d  [0:1023];
    logic         cap_cv [0:1023];
    logic         cap_c  [0:1023];
    int           cap_n = 0;

    always @(negedge clk) begin
        if (dout_valid) begin
            cap_d[cap_n]  = dout;
            cap_cv[cap_n] = comp_valid;
            cap_c[cap_n]  = comp;
            $display("cap %0d data=%06h comp_valid=%b comp=%b cnt=%0d state=%0d",
                     cap_n, dout, comp_valid, comp, mismatch_cnt, state);
            cap_n++;
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] pat(input int k);
        return 24'h3C0000 + W'(k * 7 + 1);
    endfunction

    task automatic push(input logic [W-1:0] w);
        mem[wr_cnt] = w;
        wr_cnt++;
        exp_q.push_back(w);
    endtask

    task automatic wait_caps(input string tag, input int target, input int budget);
        int i;
        i = 0;
        while (cap_n < target && i < budget) begin
            @(negedge clk);
            i++;
        end
        check({tag, "_ncap"}, 32'(cap_n >= target), 32'd1);
    endtask

    // Captures k < OFF must be unqualified; later ones compare equal except in [bad_lo, bad_hi].
    task automatic check_stream(input string tag, input int base, input int n,
                                input int bad_lo, input int bad_hi);
        logic cv;
        for (int k = 0; k < n; k++) begin
            cv = (k >= OFF);
            check($sformatf("%s_d%0d", tag, k), 32'(cap_d[base+k]), 32'(exp_q[k]));
            check($sformatf("%s_cv%0d", tag, k), 32'(cap_cv[base+k]), 32'(cv));
            check($sformatf("%s_c%0d", tag, k), 32'(cap_c[base+k]),
                  32'(cv && !(k >= bad_lo && k <= bad_hi)));
        end
    endtask

    // Park in IDLE with empty history and cleared counters.
    task automatic start_test(output int base);
        enable = 1'b0;
        repeat (3) step();
        restart = 1'b1;
        step();
        restart = 1'b0;
        clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0;
        exp_q.delete();
        base = cap_n;
    endtask

    int base;
    int i;

    initial begin
        rst_n   = 1'b0;
        enable  = 1'b0;
        restart = 1'b0;
        clr_cnt = 1'b0;

        // Reset state
        repeat (3) step();
        check("rst_state", 32'(state), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_dv", 32'(dout_valid), 32'd0);
        check("rst_cv", 32'(comp_valid), 32'd0);
        check("rst_comp", 32'(comp), 32'd0);
        check("rst_cnt", 32'(mismatch_cnt), 32'd0);
        check("rst_err", 32'(err_sticky), 32'd0);
        check("rst_rden", 32'(fifo_if.fifo_rd_en), 32'd0);
        rst_n = 1'b1;
        step();

        // Matching stream: 24 priming captures then 24 equal comparisons
        start_test(base);
        for (int k = 0; k < 48; k++) push(pat(k % OFF));
        enable = 1'b1;
        wait_caps("t32", base + 48, 400);
        check_stream("t32", base, 48, 100, 100);
        repeat (3) step();
        check("t32_cnt", 32'(mismatch_cnt), 32'd0);
        check("t32_err", 32'(err_sticky), 32'd0);
        check("t32_state", 32'(state), 32'd2);

        // One corrupted word at index 30
        start_test(base);
        check("t33_state_idle", 32'(state), 32'd0);
        for (int k = 0; k < 48; k++) push((k == 30) ? 24'hFFFFFF : pat(k % OFF));
        enable = 1'b1;
        wait_caps("t33", base + 48, 400);
        check_stream("t33", base, 48, 30, 30);
        repeat (3) step();
        check("t33_cnt", 32'(mismatch_cnt), 32'd1);
        check("t33_err", 32'(err_sticky), 32'd1);

        // Bursty FIFO and a 5-cycle enable drop mid-stream
        start_test(base);
        check("t34_clr_cnt", 32'(mismatch_cnt), 32'd0);
        check("t34_clr_err", 32'(err_sticky), 32'd0);
        for (int k = 0; k < 48; k++) push(pat(k % OFF));
        enable = 1'b1;
        fork
            begin
                for (int t = 0; t < 60; t++) begin
                    repeat (3) step();
                    empty_force = ~empty_force;
                end
                empty_force = 1'b0;
            end
            begin
                repeat (40) step();
                enable = 1'b0;
                repeat (5) step();
                enable = 1'b1;
            end
        join
        wait_caps("t34", base + 48, 400);
        check("t34_exact", 32'(cap_n - base), 32'd48);
        check_stream("t34", base, 48, 100, 100);
        repeat (3) step();
        check("t34_cnt", 32'(mismatch_cnt), 32'd0);

        // Saturation of a 2-bit counter, then clear racing a mismatch
        start_test(base);
        for (int k = 0; k < 29; k++) push((k < OFF) ? pat(k) : ~pat(k - OFF));
        enable = 1'b1;
        wait_caps("t35", base + 29, 300);
        check_stream("t35", base, 29, 24, 28);
        repeat (3) step();
        check("t35_sat", 32'(mismatch_cnt), 32'd3);
        check("t35_err", 32'(err_sticky), 32'd1);
        push(~pat(5));
        i = 0;
        while (!comp_valid && i < 100) begin
            @(negedge clk);
            i++;
        end
        check("t35_cv_seen", 32'(comp_valid), 32'd1);
        check("t35_mis_seen", 32'(comp), 32'd0);
        clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0;
        step();
        check("t35_clr_cnt", 32'(mismatch_cnt), 32'd0);
        check("t35_clr_err", 32'(err_sticky), 32'd0);

        // Restart after 30 captures forces a full re-prime
        start_test(base);
        for (int k = 0; k < 30; k++) push(pat(k % OFF));
        enable = 1'b1;
        wait_caps("t36a", base + 30, 300);
        check_stream("t36a", base, 30, 100, 100);
        step();
        check("t36_state_check", 32'(state), 32'd2);
        restart = 1'b1;
        step();
        restart = 1'b0;
        check("t36_state_prime", 32'(state), 32'd1);
        exp_q.delete();
        base = cap_n;
        for (int k = 0; k < 48; k++) push(pat((k + 11) % OFF));
        wait_caps("t36b", base + 48, 400);
        check_stream("t36b", base, 48, 100, 100);
        step();
        check("t36_state_end", 32'(state), 32'd2);

        // Asynchronous reset mid-CHECK with a pop outstanding
        start_test(base);
        for (int k = 0; k < 90; k++) push(24'h5A5A5A);
        enable = 1'b1;
        wait_caps("t37a", base + 30, 300);
        step();
        check("t37_rden_pre", 32'(fifo_if.fifo_rd_en), 32'd1);
        check("t37_state_pre", 32'(state), 32'd2);
        rst_n = 1'b0;
        #1;
        check("t37_rst_state", 32'(state), 32'd0);
        check("t37_rst_dv", 32'(dout_valid), 32'd0);
        check("t37_rst_cv", 32'(comp_valid), 32'd0);
        check("t37_rst_dout", 32'(dout), 32'd0);
        check("t37_rst_rden", 32'(fifo_if.fifo_rd_en), 32'd0);
        step();
        rst_n = 1'b1;
        base = cap_n;
        wait_caps("t37b", base + 30, 300);
        for (int k = 0; k < 30; k++) begin
            check($sformatf("t37_d%0d", k), 32'(cap_d[base+k]), 32'h5A5A5A);
            check($sformatf("t37_cv%0d", k), 32'(cap_cv[base+k]), 32'(k >= OFF));
            check($sformatf("t37_c%0d", k), 32'(cap_c[base+k]), 32'(k >= OFF));
        end
        check("t37_cnt", 32'(mismatch_cnt), 32'd0);
        enable = 1'b0;
        repeat (3) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
